// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
//
// Supervises the core PLL from the free-running reference clock. It pulses the
// PLL reset, waits for lock (retrying after a timeout), holds the core in reset
// until lock has been stable for STABLE_CYCLES, and keeps saturating counts of
// lock timeouts and of lock drops seen while running.
//
// Ports:
//   clk             reference clock (PLL refclk domain)
//   rst             synchronous active-high reset
//   locked          PLL lock, asynchronous to clk (2-FF synchronized inside)
//   ext_reset_req   forces a full PLL re-lock; wins over every other transition
//   pll_rst         drives the PLL reset input
//   core_reset      reset for downstream logic (consumer resynchronizes it)
//   ready           ~core_reset
//   retry_count     lock timeouts, saturating at 2^CNT_W-1
//   lock_loss_count lock drops while in RUN, saturating at 2^CNT_W-1
//   state_o         0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN
//
// Build option:
//   PLL_SUPERVISOR_LOCK_DEGLITCH_EN - when defined, a lock drop in RUN only
//   counts once locked_s has been low for 4 consecutive cycles. When undefined,
//   a single low cycle of locked_s in RUN is a lock loss.
// -----------------------------------------------------------------------------
module pll_supervisor #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             ext_reset_req,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [1:0]       state_o
);

  localparam int MAX_AB = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  // Terminal counts; every one of them forces a state change, so the timer
  // never needs to wrap.
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t           state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             pll_rst_reg;
  logic             core_reset_reg;
  logic [CNT_W-1:0] retry_count_reg;
  logic [CNT_W-1:0] lock_loss_count_reg;
  logic [1:0]       sync_reg;
  logic             locked_s;
  logic             lock_lost;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], locked};
    end
  end

  assign locked_s = sync_reg[1];

`ifdef PLL_SUPERVISOR_LOCK_DEGLITCH_EN
  // Run length of consecutive low locked_s cycles while running. The loss is
  // declared on the 4th low cycle: the counter already holds 3 and locked_s
  // is still low.
  logic [1:0] low_run_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      low_run_reg <= 2'd0;
    end else if (ext_reset_req || state_reg != ST_RUN || locked_s) begin
      low_run_reg <= 2'd0;
    end else if (low_run_reg != 2'd3) begin
      low_run_reg <= low_run_reg + 2'd1;
    end
  end

  assign lock_lost = ~locked_s && (low_run_reg == 2'd3);
`else
  assign lock_lost = ~locked_s;
`endif

  // Sequencer. Outputs are registered alongside the state so they change on
  // the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= ST_RESET_PLL;
      timer_reg           <= '0;
      pll_rst_reg         <= 1'b1;
      core_reset_reg      <= 1'b1;
      retry_count_reg     <= '0;
      lock_loss_count_reg <= '0;
    end else if (ext_reset_req) begin
      state_reg      <= ST_RESET_PLL;
      timer_reg      <= '0;
      pll_rst_reg    <= 1'b1;
      core_reset_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_RESET_PLL: begin
          core_reset_reg <= 1'b1;
          if (timer_reg == RST_LAST) begin
            state_reg   <= ST_WAIT_LOCK;
            timer_reg   <= '0;
            pll_rst_reg <= 1'b0;
          end else begin
            timer_reg   <= timer_reg + 1'b1;
            pll_rst_reg <= 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          core_reset_reg <= 1'b1;
          // Lock is checked first so a lock arriving on the timeout cycle
          // is not counted as a retry.
          if (locked_s) begin
            state_reg <= ST_STABILIZE;
            timer_reg <= '0;
          end else if (timer_reg == TIMEOUT_LAST) begin
            state_reg   <= ST_RESET_PLL;
            timer_reg   <= '0;
            pll_rst_reg <= 1'b1;
            if (retry_count_reg != CNT_MAX) begin
              retry_count_reg <= retry_count_reg + 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_STABILIZE: begin
          // Unfiltered: any low cycle restarts the wait for lock.
          if (!locked_s) begin
            state_reg <= ST_WAIT_LOCK;
            timer_reg <= '0;
          end else if (timer_reg == STABLE_LAST) begin
            state_reg      <= ST_RUN;
            timer_reg      <= '0;
            core_reset_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_RUN: begin
          // The PLL is not reset on a lock drop; it is given the chance to
          // re-acquire within the normal lock timeout.
          if (lock_lost) begin
            state_reg      <= ST_WAIT_LOCK;
            timer_reg      <= '0;
            core_reset_reg <= 1'b1;
            if (lock_loss_count_reg != CNT_MAX) begin
              lock_loss_count_reg <= lock_loss_count_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg      <= ST_RESET_PLL;
          timer_reg      <= '0;
          pll_rst_reg    <= 1'b1;
          core_reset_reg <= 1'b1;
        end
      endcase
    end
  end

  assign pll_rst         = pll_rst_reg;
  assign core_reset      = core_reset_reg;
  assign ready           = ~core_reset_reg;
  assign retry_count     = retry_count_reg;
  assign lock_loss_count = lock_loss_count_reg;
  assign state_o         = state_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_supervisor
//
// Directed bench for pll_supervisor with RST_PULSE=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, CNT_W=4. Outputs are sampled 1 ns after each rising edge;
// inputs are changed at the same point. Expected edge counts below are
// measured from the sample point at which the stimulus was applied.
// Honours PLL_SUPERVISOR_LOCK_DEGLITCH_EN for the RUN lock-loss cases.
// -----------------------------------------------------------------------------
module tb_pll_supervisor;

  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 4;
  localparam int SYNC_LAT      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             locked;
  logic             ext_reset_req;
  logic             pll_rst;
  logic             core_reset;
  logic             ready;
  logic [CNT_W-1:0] retry_count;
  logic [CNT_W-1:0] lock_loss_count;
  logic [1:0]       state_o;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_loss = 0;
  int n;

  pll_supervisor #(
    .RST_PULSE    (RST_PULSE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .locked         (locked),
    .ext_reset_req  (ext_reset_req),
    .pll_rst        (pll_rst),
    .core_reset     (core_reset),
    .ready          (ready),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state_o        (state_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps until the selected output (0 pll_rst, 1 core_reset, 2 state_o)
  // equals val; returns the number of edges taken, or -1 on timeout.
  task automatic wait_for(input int sel, input int val, output int edges);
    int got_v;
    edges = -1;
    for (int i = 1; i <= 200 && edges < 0; i++) begin
      step(1);
      case (sel)
        0:       got_v = int'(pll_rst);
        1:       got_v = int'(core_reset);
        default: got_v = int'(state_o);
      endcase
      if (got_v == val) edges = i;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset values ----------------
    rst = 1'b1; locked = 1'b0; ext_reset_req = 1'b0;
    step(3);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_core_reset", int'(core_reset), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_retry", int'(retry_count), 0);
    chk("rst_loss", int'(lock_loss_count), 0);

    // ---------------- no lock: retries until saturation ----------------
    rst = 1'b0;
    wait_for(0, 0, n);
    chk("pulse_len_1", n, RST_PULSE);
    wait_for(0, 1, n);
    chk("timeout_len_1", n, LOCK_TIMEOUT);
    chk("retry_1", int'(retry_count), 1);
    chk("state_after_retry", int'(state_o), 0);
    for (int r = 2; r <= 17; r++) begin
      wait_for(0, 0, n);
      chk($sformatf("pulse_len_%0d", r), n, RST_PULSE);
      wait_for(0, 1, n);
      chk($sformatf("timeout_len_%0d", r), n, LOCK_TIMEOUT);
      chk($sformatf("retry_%0d", r), int'(retry_count), (r > 15) ? 15 : r);
    end

    // ---------------- normal lock ----------------
    rst = 1'b1;
    step(1);
    chk("rst_clears_retry", int'(retry_count), 0);
    rst = 1'b0;
    wait_for(0, 0, n);
    chk("pulse_len_lock", n, RST_PULSE);
    step(10);
    locked = 1'b1;
    // sync edges, one edge for WAIT_LOCK to react, then STABLE_CYCLES
    wait_for(1, 0, n);
    chk("lock_to_release", n, SYNC_LAT + 1 + STABLE_CYCLES);
    chk("ready_after_lock", int'(ready), 1);
    chk("state_run", int'(state_o), 3);
    chk("retry_after_lock", int'(retry_count), 0);

    // ---------------- lock on the timeout cycle, then STABILIZE dropout ----
    rst = 1'b1; locked = 1'b0;
    step(1);
    rst = 1'b0;
    wait_for(0, 0, n);
    chk("pulse_len_race", n, RST_PULSE);
    // locked_s first seen by the FSM on the edge where timer = LOCK_TIMEOUT-1
    step(LOCK_TIMEOUT - 3);
    locked = 1'b1;
    step(2);
    chk("race_still_wait", int'(state_o), 1);
    step(1);
    chk("race_lock_wins", int'(state_o), 2);
    chk("race_no_retry", int'(retry_count), 0);
    chk("race_pll_rst", int'(pll_rst), 0);
    step(2);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    wait_for(2, 1, n);
    chk("stab_drop_to_wait", n, 2);
    chk("stab_drop_core_reset", int'(core_reset), 1);
    wait_for(1, 0, n);
    chk("restabilize", n, 1 + STABLE_CYCLES);
    chk("stab_drop_loss", int'(lock_loss_count), 0);

    // ---------------- RUN: 1-cycle dropout ----------------
    step(3);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
`ifdef PLL_SUPERVISOR_LOCK_DEGLITCH_EN
    step(2);
    chk("glitch1_ignored", int'(core_reset), 0);
    step(6);
    chk("glitch1_state", int'(state_o), 3);
    chk("glitch1_loss", int'(lock_loss_count), 0);
    // 3-cycle dropout is still under the filter threshold
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    step(8);
    chk("glitch3_state", int'(state_o), 3);
    chk("glitch3_loss", int'(lock_loss_count), 0);
`else
    step(1);
    chk("glitch1_not_early", int'(core_reset), 0);
    step(1);
    chk("glitch1_core_reset", int'(core_reset), 1);
    chk("glitch1_state", int'(state_o), 1);
    chk("glitch1_pll_rst", int'(pll_rst), 0);
    exp_loss = 1;
    chk("glitch1_loss", int'(lock_loss_count), exp_loss);
    wait_for(1, 0, n);
    chk("glitch1_rerelease", n, 1 + STABLE_CYCLES);
`endif

    // ---------------- RUN: 5-cycle dropout ----------------
    locked = 1'b0;
    step(5);
    locked = 1'b1;
    step(3);
    exp_loss = exp_loss + 1;
    chk("drop5_state", int'(state_o), 2);
    chk("drop5_loss", int'(lock_loss_count), exp_loss);
    wait_for(1, 0, n);
    chk("drop5_rerelease", n, STABLE_CYCLES);

    // ---------------- ext_reset_req pulse in RUN ----------------
    ext_reset_req = 1'b1;
    step(1);
    ext_reset_req = 1'b0;
    chk("ext_state", int'(state_o), 0);
    chk("ext_core_reset", int'(core_reset), 1);
    chk("ext_pll_rst", int'(pll_rst), 1);
    chk("ext_ready", int'(ready), 0);
    chk("ext_loss_kept", int'(lock_loss_count), exp_loss);
    chk("ext_retry_kept", int'(retry_count), 0);
    wait_for(0, 0, n);
    chk("ext_pulse_len", n, RST_PULSE);
    step(1);
    chk("ext_relock_stab", int'(state_o), 2);

    // ---------------- rst mid-STABILIZE ----------------
    rst = 1'b1;
    step(1);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_pll_rst", int'(pll_rst), 1);
    chk("midrst_core_reset", int'(core_reset), 1);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_loss", int'(lock_loss_count), 0);
    chk("midrst_retry", int'(retry_count), 0);

    // ---------------- ext_reset_req held ----------------
    rst = 1'b0;
    ext_reset_req = 1'b1;
    step(10);
    chk("ext_held_state", int'(state_o), 0);
    chk("ext_held_pll_rst", int'(pll_rst), 1);
    ext_reset_req = 1'b0;
    wait_for(0, 0, n);
    chk("ext_held_release", n, RST_PULSE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
